// File: rtl/gene_pkg.sv
// Shared definitions for the alignment datapath: op codes, traceback matrices,
// direction-word field positions and the traceback FSM state encoding.
// Contains no logic, so it has no latency or backpressure behaviour.
package gene_pkg;

    // Op codes deliberately equal the PE v_direct encoding, so V-matrix decode
    // can forward the stored field unchanged.
    localparam logic [1:0] OP_DIAG   = 2'd0;
    localparam logic [1:0] OP_DEL    = 2'd1;
    localparam logic [1:0] OP_INS    = 2'd2;
    localparam logic [1:0] V_ILLEGAL = 2'd3;

    // Direction word layout: {d_direct, i_direct, v_direct[1:0]}
    localparam int DIR_V_LSB = 0;
    localparam int DIR_V_MSB = 1;
    localparam int DIR_I_BIT = 2;
    localparam int DIR_D_BIT = 3;

    typedef enum logic [1:0] {
        MAT_V = 2'd0,
        MAT_I = 2'd1,
        MAT_D = 2'd2
    } mat_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } tb_state_e;

    // The exit bit of a gap matrix: 1 returns to V, 0 keeps extending the gap.
    function automatic mat_e gap_next(input logic exit_bit, input mat_e gap_mat);
        return exit_bit ? MAT_V : gap_mat;
    endfunction

endpackage

// File: rtl/dir_ram.sv
// Direction RAM: one write port, one registered read port, 4-bit words.
// Read latency 1 cycle; o_rd_dat holds its value while i_rd_en is low.
// No backpressure: writes and reads are accepted every cycle they are enabled.
// Ports: i_clk; i_wr_en/i_wr_addr/i_wr_dat write port; i_rd_en/i_rd_addr read
//        request; o_rd_dat registered read data.
module dir_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [3:0]    i_wr_dat,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [3:0]    o_rd_dat
);

    logic [3:0] r_mem [DEPTH];
    logic [3:0] r_rd_dat;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/traceback_unit.sv
// Gotoh three-matrix traceback: stores PE direction words, then walks an end cell back to (0,0).
// Latency: start->first op 2 cycles; interior ops every 2 cycles, boundary ops every cycle.
// Backpressure: op fields hold steady while o_op_valid && !i_op_ready; writes while busy are dropped.
// Ports: i_clk/i_rst; i_wr_en/i_wr_row/i_wr_col/i_wr_dir direction write; i_start/i_end_row/i_end_col
//        command; o_op_valid/o_op/o_op_row/o_op_col/i_op_ready op stream; o_busy, o_done, o_err status.
module traceback_unit
    import gene_pkg::*;
#(
    parameter int MAX_ROWS = 64,
    parameter int MAX_COLS = 64,
    parameter int ROW_W    = $clog2(MAX_ROWS + 1),
    parameter int COL_W    = $clog2(MAX_COLS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [ROW_W-1:0] i_wr_row,
    input  logic [COL_W-1:0] i_wr_col,
    input  logic [3:0]       i_wr_dir,
    input  logic             i_start,
    input  logic [ROW_W-1:0] i_end_row,
    input  logic [COL_W-1:0] i_end_col,
    output logic             o_busy,
    output logic             o_op_valid,
    output logic [1:0]       o_op,
    output logic [ROW_W-1:0] o_op_row,
    output logic [COL_W-1:0] o_op_col,
    input  logic             i_op_ready,
    output logic             o_done,
    output logic             o_err
);

    localparam int DEPTH = MAX_ROWS * MAX_COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [ROW_W-1:0] LP_ROW_MAX = ROW_W'(MAX_ROWS);
    localparam logic [COL_W-1:0] LP_COL_MAX = COL_W'(MAX_COLS);

    function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
        return AW'((int'(row) - 1) * MAX_COLS + (int'(col) - 1));
    endfunction

    tb_state_e        r_state;
    mat_e             r_mat;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_wr_ok;
    logic             w_rd_en;
    logic [3:0]       w_dir_q;
    logic [1:0]       w_op;
    logic [ROW_W-1:0] w_nxt_row;
    logic [COL_W-1:0] w_nxt_col;
    mat_e             w_nxt_mat;
    logic             w_illegal;
    logic             w_valid;

    // Out-of-range write coordinates are ignored rather than aliased into other cells.
    assign w_wr_ok = i_wr_en && (r_state == ST_IDLE)
                     && (i_wr_row != '0) && (i_wr_row <= LP_ROW_MAX)
                     && (i_wr_col != '0) && (i_wr_col <= LP_COL_MAX);

    // Boundary cells have no stored direction, so no read is issued for them.
    assign w_rd_en = (r_state == ST_READ) && (r_row != '0) && (r_col != '0);

    // The RAM output register only updates in READ, so it doubles as dir_q during EMIT.
    dir_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dir_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (cell_addr(i_wr_row, i_wr_col)),
        .i_wr_dat  (i_wr_dir),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (cell_addr(r_row, r_col)),
        .o_rd_dat  (w_dir_q)
    );

    // Step decode for the current cell; boundaries override the matrix state.
    always_comb begin
        w_op      = OP_DIAG;
        w_nxt_row = r_row;
        w_nxt_col = r_col;
        w_nxt_mat = r_mat;
        w_illegal = 1'b0;
        if (r_row == '0) begin
            w_op      = OP_INS;
            w_nxt_col = r_col - COL_W'(1);
        end else if (r_col == '0) begin
            w_op      = OP_DEL;
            w_nxt_row = r_row - ROW_W'(1);
        end else begin
            case (r_mat)
                MAT_V: begin
                    case (w_dir_q[DIR_V_MSB:DIR_V_LSB])
                        OP_DIAG: begin
                            w_op      = OP_DIAG;
                            w_nxt_row = r_row - ROW_W'(1);
                            w_nxt_col = r_col - COL_W'(1);
                        end
                        OP_DEL: begin
                            w_op      = OP_DEL;
                            w_nxt_row = r_row - ROW_W'(1);
                            w_nxt_mat = gap_next(w_dir_q[DIR_D_BIT], MAT_D);
                        end
                        OP_INS: begin
                            w_op      = OP_INS;
                            w_nxt_col = r_col - COL_W'(1);
                            w_nxt_mat = gap_next(w_dir_q[DIR_I_BIT], MAT_I);
                        end
                        default: w_illegal = 1'b1;
                    endcase
                end
                MAT_D: begin
                    w_op      = OP_DEL;
                    w_nxt_row = r_row - ROW_W'(1);
                    w_nxt_mat = gap_next(w_dir_q[DIR_D_BIT], MAT_D);
                end
                default: begin
                    w_op      = OP_INS;
                    w_nxt_col = r_col - COL_W'(1);
                    w_nxt_mat = gap_next(w_dir_q[DIR_I_BIT], MAT_I);
                end
            endcase
        end
    end

    // Op fields are decoded from registered state only, and forced to zero when
    // not valid so idle/reset outputs read as 0.
    assign w_valid    = (r_state == ST_EMIT) && !w_illegal;
    assign o_op_valid = w_valid;
    assign o_op       = w_valid ? w_op  : 2'd0;
    assign o_op_row   = w_valid ? r_row : '0;
    assign o_op_col   = w_valid ? r_col : '0;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_mat   <= MAT_V;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (i_end_row == '0 && i_end_col == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (i_end_row > LP_ROW_MAX || i_end_col > LP_COL_MAX) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_row   <= i_end_row;
                            r_col   <= i_end_col;
                            r_mat   <= MAT_V;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: r_state <= ST_EMIT;
                ST_EMIT: begin
                    if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (i_op_ready) begin
                        r_row <= w_nxt_row;
                        r_col <= w_nxt_col;
                        r_mat <= w_nxt_mat;
                        if (w_nxt_row == '0 && w_nxt_col == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (w_nxt_row == '0 || w_nxt_col == '0) begin
                            r_state <= ST_EMIT;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/traceback_unit.md
Name: traceback_unit

Overview:
- Downstream consumer of the affine-gap PE array.
- Stores the per-cell direction bits (v_direct, i_direct, d_direct) into a local direction RAM during scoring.
- On command, walks back from a given end cell to (0,0) with Gotoh three-matrix traceback, emitting one alignment op per handshake.
- Ops feed the CIGAR/alignment-output stage.

Parameters:
- MAX_ROWS, 64, maximum query length (cells 1..MAX_ROWS).
- MAX_COLS, 64, maximum reference length (cells 1..MAX_COLS).
- ROW_W, $clog2(MAX_ROWS+1), row index width.
- COL_W, $clog2(MAX_COLS+1), column index width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_wr_en  in  1  direction write strobe from the PE array
- i_wr_row  in  ROW_W  cell row, 1..MAX_ROWS
- i_wr_col  in  COL_W  cell column, 1..MAX_COLS
- i_wr_dir  in  4  {d_direct, i_direct, v_direct[1:0]}
- i_start  in  1  start traceback (single-cycle pulse)
- i_end_row  in  ROW_W  traceback start row
- i_end_col  in  COL_W  traceback start column
- o_busy  out  1  traceback in progress
- o_op_valid  out  1  op output valid
- o_op  out  2  0 DIAG, 1 DEL (up), 2 INS (left)
- o_op_row  out  ROW_W  row of the cell the op belongs to
- o_op_col  out  COL_W  column of the cell the op belongs to
- i_op_ready  in  1  downstream accepts op
- o_done  out  1  one-cycle pulse when traceback completes
- o_err  out  1  sticky error, cleared by the next accepted i_start

Behaviour:
- Clocking: one clock, i_clk; reset i_rst is synchronous, active-high.
- Reset values: all outputs 0, FSM in IDLE, cur_mat = V. RAM contents are not reset.
- RAM: MAX_ROWS*MAX_COLS x 4 bits, synchronous read with 1-cycle latency.
  - Address = (row-1)*MAX_COLS + (col-1).
  - A write occurs only when i_wr_en=1 and the FSM is IDLE; writes while busy are dropped.
- FSM states: IDLE, READ, EMIT, DONE.
- IDLE:
  - i_start with end=(0,0) -> DONE, no ops emitted.
  - i_start with end_row>MAX_ROWS or end_col>MAX_COLS -> o_err=1, then DONE.
  - Otherwise load r, c, cur_mat=V, then -> READ.
- READ: drive the RAM address for (r,c); -> EMIT next cycle and latch the RAM data into dir_q.
- EMIT: o_op_valid=1. o_op, o_op_row and o_op_col stay stable until i_op_ready=1.
- Op selection in EMIT:
  - Boundary r==0: op=INS, c-=1.
  - Boundary c==0: op=DEL, r-=1.
  - cur_mat=V, v_direct=0: op=DIAG, r-=1, c-=1, stay V.
  - cur_mat=V, v_direct=1: op=DEL, r-=1, next mat = d_direct ? V : D.
  - cur_mat=V, v_direct=2: op=INS, c-=1, next mat = i_direct ? V : I.
  - cur_mat=V, v_direct=3: illegal -> o_err=1, no op, -> DONE.
  - cur_mat=D: op=DEL, r-=1, next mat = d_direct ? V : D.
  - cur_mat=I: op=INS, c-=1, next mat = i_direct ? V : I.
- After a handshake in EMIT:
  - new (r,c)==(0,0) -> DONE.
  - new r==0 or c==0 -> stay EMIT (boundary ops need no RAM read).
  - Otherwise -> READ.
  - Interior throughput is 1 op per 2 cycles; boundary throughput is 1 op per cycle.
- DONE: o_done=1 for one cycle, then -> IDLE. o_busy=1 in READ, EMIT and DONE.
- Simultaneous events:
  - i_start while busy is ignored.
  - i_start and i_wr_en in the same IDLE cycle: the write is performed and the traceback starts.
  - A read in the following READ cycle sees the new data.
- i_rst mid-traceback returns to IDLE next edge and drops o_op_valid; no o_done is produced.
- Op count always equals the number of steps to reach (0,0). DIAG+DEL count = end_row; DIAG+INS count = end_col.

Decomposition:
- Shared package gene_pkg:
  - Op codes OP_DIAG/OP_DEL/OP_INS, equal to the PE v_direct encoding.
  - Matrix enum MAT_V/MAT_I/MAT_D.
  - Direction field bit positions.
- Sub-module dir_ram: single-port write, sync-read, 4-bit, depth MAX_ROWS*MAX_COLS.
- Address and step logic stay in traceback_unit.

Test Plan:
1. 2x2 all cells dir=4'b0000, start (2,2), ready=1 -> ops DIAG@(2,2), DIAG@(1,1), then o_done; 2 ops total.
2. Cell (3,1) v_direct=1, d_direct=0; cell (2,1) d_direct=1; cell (1,1) dir=0; start (3,1) -> DEL@(3,1), DEL@(2,1), DIAG@(1,1), done.
3. Cell (1,3) v_direct=2, i_direct=1; start (1,3) -> INS@(1,3), then V at (1,2): program (1,2)=DIAG -> DIAG@(1,2), INS@(0,1) boundary, done; 3 ops.
4. Start (0,3) -> three INS ops on consecutive ready cycles, cols 3,2,1, then o_done.
5. Hold i_op_ready=0 for 5 cycles mid-trace -> o_op/o_op_row/o_op_col stable; writes during this window are dropped (RAM readback unchanged).
6. Cell dir v_direct=3 at the start cell -> o_err=1, no op_valid, o_done pulse. i_rst asserted in EMIT -> next cycle o_op_valid=0 and o_busy=0.
